// File: rtl/spmv_mem_model_pkg.sv
// Shared helpers for the spmv_mem_model memory model: time-stamp width
// derivation, occupancy counter width and response-queue entry layout.
// Entry layout, LSB first: {tag, data, due} -> due at [TS_W-1:0],
// data at [TS_W +: DATA_W], tag at [TS_W+DATA_W +: TAG_W].
package spmv_mem_model_pkg;

    // Time-stamp width: wide enough that the oldest possible head age
    // (LATENCY + MAX_OUTSTANDING) stays below half the counter range.
    function automatic int ts_width(input int latency, input int max_out);
        return $clog2(latency + max_out + 1) + 1;
    endfunction

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit offset of the data field inside a queue entry.
    function automatic int ent_data_lsb(input int ts_w);
        return ts_w;
    endfunction

    // Bit offset of the tag field inside a queue entry.
    function automatic int ent_tag_lsb(input int ts_w, input int data_w);
        return ts_w + data_w;
    endfunction

endpackage

// File: rtl/spmv_mem_model_fifo.sv
// Synchronous FIFO holding in-flight load responses. Pointers and count
// are reset asynchronously; the storage array is not reset. Push while
// full and pop while empty are ignored.
module spmv_mem_model_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];

    // Write the accepted entry into storage
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Advance pointers and track occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spmv_mem_model.sv
// Word-addressed backing store for spmv_pe. Stores complete at the
// sampling edge; loads read at the sampling edge and are returned in
// order after LATENCY cycles. A frozen time base implements response
// back-pressure, and sticky flags report dropped requests.
module spmv_mem_model
    import spmv_mem_model_pkg::*;
#(
    parameter int ADDR_W          = 48,
    parameter int DATA_W          = 64,
    parameter int TAG_W           = 3,
    parameter int MEM_LOG2        = 20,
    parameter int LATENCY         = 1000,
    parameter int MAX_OUTSTANDING = 64,
    parameter int STALL_SLACK     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_mem_ld,
    input  logic              req_mem_st,
    input  logic [ADDR_W-1:0] req_mem_addr,
    input  logic [DATA_W-1:0] req_mem_d_or_tag,
    output logic              req_mem_stall,
    output logic              rsp_mem_push,
    output logic [TAG_W-1:0]  rsp_mem_tag,
    output logic [DATA_W-1:0] rsp_mem_q,
    input  logic              rsp_mem_stall,
    output logic              err_overflow,
    output logic              err_both
);

    localparam int TS_W      = ts_width(LATENCY, MAX_OUTSTANDING);
    localparam int ENT_W     = TAG_W + DATA_W + TS_W;
    localparam int CNT_W     = count_width(MAX_OUTSTANDING);
    localparam int DATA_LSB  = ent_data_lsb(TS_W);
    localparam int TAG_LSB   = ent_tag_lsb(TS_W, DATA_W);
    localparam int MEM_DEPTH = 1 << MEM_LOG2;
    localparam logic [CNT_W-1:0] STALL_THRESH = CNT_W'(MAX_OUTSTANDING - STALL_SLACK);

    logic [DATA_W-1:0]   store_r [MEM_DEPTH];
    logic [MEM_LOG2-1:0] word_idx_s;
    logic                addr_unused_s;
    logic [DATA_W-1:0]   rd_data_s;

    logic [TS_W-1:0]     now_r;
    logic [TS_W-1:0]     now_next_s;
    logic [TS_W-1:0]     due_s;
    logic [TS_W-1:0]     age_s;

    logic                ld_ok_s;
    logic                drop_full_s;
    logic                both_s;
    logic                matured_s;
    logic                pop_s;

    logic [ENT_W-1:0]    enq_ent_s;
    logic [ENT_W-1:0]    head_s;
    logic [CNT_W-1:0]    count_s;
    logic [CNT_W-1:0]    count_next_s;
    logic                full_s;
    logic                empty_s;

    logic                push_r;
    logic [TAG_W-1:0]    tag_r;
    logic [DATA_W-1:0]   q_r;
    logic                stall_r;
    logic                err_ovf_r;
    logic                err_both_r;

    // Byte offset and address bits above the store depth do not select a word.
    assign word_idx_s    = req_mem_addr[MEM_LOG2+2:3];
    assign addr_unused_s = ^{req_mem_addr[ADDR_W-1:MEM_LOG2+3], req_mem_addr[2:0]};
    assign rd_data_s     = store_r[word_idx_s];

    // A simultaneous store wins over the load; a full queue drops the load
    // even when the head pops in the same cycle.
    assign both_s      = req_mem_ld & req_mem_st;
    assign ld_ok_s     = req_mem_ld & ~req_mem_st & ~full_s;
    assign drop_full_s = req_mem_ld & ~req_mem_st & full_s;

    // The time base only advances while the consumer accepts responses, so
    // every stalled cycle pushes all pending deadlines back by one.
    assign now_next_s = rsp_mem_stall ? now_r : (now_r + TS_W'(1));

    // Stamping against the post-edge time makes the registered push land
    // exactly LATENCY cycles after the load is sampled.
    assign due_s     = now_next_s + TS_W'(LATENCY - 1);
    assign enq_ent_s = {req_mem_d_or_tag[TAG_W-1:0], rd_data_s, due_s};

    // Modular compare keeps maturity correct across time-base wrap.
    assign age_s     = now_r - head_s[TS_W-1:0];
    assign matured_s = ~empty_s & ~age_s[TS_W-1];
    assign pop_s     = matured_s & ~rsp_mem_stall;

    spmv_mem_model_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ld_ok_s),
        .pop   (pop_s),
        .wdata (enq_ent_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Occupancy after this edge, used to pre-compute the registered stall flag
    always_comb begin
        count_next_s = count_s;
        case ({ld_ok_s, pop_s})
            2'b10:   count_next_s = count_s + CNT_W'(1);
            2'b01:   count_next_s = count_s - CNT_W'(1);
            default: count_next_s = count_s;
        endcase
    end

    // Backing store write port; contents survive reset
    always_ff @(posedge clk) begin
        if (req_mem_st) begin
            store_r[word_idx_s] <= req_mem_d_or_tag;
        end
    end

    // Time base, response registers, stall flag and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_r      <= TS_W'(0);
            push_r     <= 1'b0;
            tag_r      <= TAG_W'(0);
            q_r        <= DATA_W'(0);
            stall_r    <= 1'b0;
            err_ovf_r  <= 1'b0;
            err_both_r <= 1'b0;
        end else begin
            now_r   <= now_next_s;
            push_r  <= pop_s;
            stall_r <= (count_next_s >= STALL_THRESH);
            if (pop_s) begin
                tag_r <= head_s[TAG_LSB +: TAG_W];
                q_r   <= head_s[DATA_LSB +: DATA_W];
            end
            if (both_s) begin
                err_both_r <= 1'b1;
            end
            if (drop_full_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    assign rsp_mem_push  = push_r;
    assign rsp_mem_tag   = tag_r;
    assign rsp_mem_q     = q_r;
    assign req_mem_stall = stall_r;
    assign err_overflow  = err_ovf_r;
    assign err_both      = err_both_r;

endmodule
